// File: rtl/tiny_nn_pkg.sv
// Shared numeric types for the tiny-nn datapath: a half-precision style fp_t
// with no subnormals, plus the special-value constants and classifiers.
package tiny_nn_pkg;

    localparam int FPExpWidth  = 5;
    localparam int FPMantWidth = 10;
    localparam int FPExpBias   = 2**(FPExpWidth-1) - 1;

    typedef struct packed {
        logic                   sgn;
        logic [FPExpWidth-1:0]  exp;
        logic [FPMantWidth-1:0] mant;
    } fp_t;

    localparam fp_t FPZero   = '{sgn: 1'b0, exp: '0, mant: '0};
    localparam fp_t FPPosInf = '{sgn: 1'b0, exp: '1, mant: '0};
    localparam fp_t FPNegInf = '{sgn: 1'b1, exp: '1, mant: '0};
    localparam fp_t FPStdNaN = '{sgn: 1'b0, exp: '1, mant: {1'b1, {(FPMantWidth-1){1'b0}}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_DONE
    } div_state_t;

    function automatic logic is_nan(input fp_t x);
        return (x.exp == '1) && (x.mant != '0);
    endfunction

    function automatic logic is_inf(input fp_t x);
        return (x.exp == '1) && (x.mant == '0);
    endfunction

    function automatic logic is_zero(input fp_t x);
        return (x.exp == '0) && (x.mant == '0);
    endfunction

endpackage

// File: rtl/fp_div_step.sv
// Combinational restoring-division step producing BitsPerCycle quotient bits,
// MSB first, from the current partial remainder and the divisor.
module fp_div_step
    import tiny_nn_pkg::*;
#(
    parameter int BitsPerCycle = 1,
    parameter int RW           = FPMantWidth + 2
) (
    input  logic [RW-1:0]           i_rem,
    input  logic [RW-1:0]           i_div,
    output logic [RW-1:0]           o_rem,
    output logic [BitsPerCycle-1:0] o_q
);

    logic [RW-1:0] w_rem [BitsPerCycle+1];

    assign w_rem[0] = i_rem;

    genvar gi;
    generate
        for (gi = 0; gi < BitsPerCycle; gi++) begin : g_bit
            logic          w_ge;
            logic [RW-1:0] w_diff;
            assign w_ge   = (w_rem[gi] >= i_div);
            assign w_diff = w_ge ? (w_rem[gi] - i_div) : w_rem[gi];
            // w_diff < divisor < 2^(RW-1), so the shift never loses a set bit
            assign w_rem[gi+1] = w_diff << 1;
            assign o_q[BitsPerCycle-1-gi] = w_ge;
        end
    endgenerate

    assign o_rem = w_rem[BitsPerCycle];

endmodule

// File: rtl/fp_div.sv
// Iterative restoring floating-point divider (truncating, flush-to-zero,
// saturate-to-Inf) with valid/ready handshakes on input and output.
module fp_div
    import tiny_nn_pkg::*;
#(
    parameter int BitsPerCycle = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  fp_t  op_a_i,
    input  fp_t  op_b_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output fp_t  result_o
);

    localparam int QW    = FPMantWidth + 2;
    localparam int ITERS = QW / BitsPerCycle;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int EW2   = FPExpWidth + 2;
    localparam logic signed [EW2-1:0] EXP_BIAS = EW2'(FPExpBias);
    localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((2**FPExpWidth) - 1);

    div_state_t                r_state;
    logic                      r_in_ready;
    logic                      r_out_valid;
    fp_t                       r_result;
    logic [QW-1:0]             r_rem;
    logic [QW-1:0]             r_divisor;
    logic [QW-BitsPerCycle-1:0] r_quot;
    logic [CW-1:0]             r_cnt;
    logic signed [EW2-1:0]     r_exp;
    logic                      r_sgn;

    logic [QW-1:0]             w_rem_next;
    logic [BitsPerCycle-1:0]   w_q_bits;
    logic [QW-1:0]             w_quot_next;
    logic                      w_norm;
    logic [FPMantWidth-1:0]    w_mant;
    logic signed [EW2-1:0]     w_exp_fin;
    fp_t                       w_packed;
    logic                      w_special;
    fp_t                       w_special_res;
    logic                      w_sgn_in;

    fp_div_step #(
        .BitsPerCycle (BitsPerCycle),
        .RW           (QW)
    ) u_step (
        .i_rem (r_rem),
        .i_div (r_divisor),
        .o_rem (w_rem_next),
        .o_q   (w_q_bits)
    );

    assign w_sgn_in    = op_a_i.sgn ^ op_b_i.sgn;
    assign w_quot_next = {r_quot, w_q_bits};
    // Quotient lies in (0.5, 2): a clear top bit means one extra left shift
    assign w_norm      = ~w_quot_next[QW-1];
    assign w_mant      = w_quot_next[QW-1] ? w_quot_next[QW-2:1] : w_quot_next[QW-3:0];
    assign w_exp_fin   = r_exp - $signed({{(EW2-1){1'b0}}, w_norm});

    always_comb begin
        w_packed = '{sgn: r_sgn, exp: w_exp_fin[FPExpWidth-1:0], mant: w_mant};
        if (w_exp_fin <= 0) begin
            w_packed = FPZero;
        end else if (w_exp_fin >= EXP_MAX) begin
            w_packed = r_sgn ? FPNegInf : FPPosInf;
        end
    end

    always_comb begin
        w_special     = 1'b1;
        w_special_res = FPZero;
        if (is_nan(op_a_i) || is_nan(op_b_i) ||
            (is_zero(op_a_i) && is_zero(op_b_i)) ||
            (is_inf(op_a_i) && is_inf(op_b_i))) begin
            w_special_res = FPStdNaN;
        end else if (is_zero(op_b_i) || is_inf(op_a_i)) begin
            w_special_res = w_sgn_in ? FPNegInf : FPPosInf;
        end else if (is_zero(op_a_i) || is_inf(op_b_i)) begin
            w_special_res = FPZero;
        end else begin
            w_special = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= FPZero;
            r_rem       <= '0;
            r_divisor   <= '0;
            r_quot      <= '0;
            r_cnt       <= '0;
            r_exp       <= '0;
            r_sgn       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_sgn      <= w_sgn_in;
                        r_exp      <= $signed({2'b00, op_a_i.exp}) - $signed({2'b00, op_b_i.exp}) + EXP_BIAS;
                        r_in_ready <= 1'b0;
                        if (w_special) begin
                            r_result    <= w_special_res;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_rem     <= {2'b01, op_a_i.mant};
                            r_divisor <= {2'b01, op_b_i.mant};
                            r_quot    <= '0;
                            r_cnt     <= '0;
                            r_state   <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    r_rem  <= w_rem_next;
                    r_quot <= w_quot_next[QW-BitsPerCycle-1:0];
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CW'(ITERS-1)) begin
                        r_result    <= w_packed;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign result_o    = r_result;

endmodule
